// File: rtl/mby_msh_row_rd_req_ctrl_pkg.sv
// Shared types and sizing for the mesh row read-request controller.
// One controller instance serves one mesh plane.
package mby_msh_pkg;

  localparam int unsigned NUM_MSH_PLANES       = 4;
  localparam int unsigned MSH_ROW_RD_REQ_W     = 32;
  localparam int unsigned MSH_ROW_RD_RSP_W     = 24;
  localparam int unsigned MSH_DBUS_W           = 512;
  localparam int unsigned MSH_CRDT_W           = 4;
  localparam int unsigned MSH_ROW_RD_REQ_CRDTS = 8;
  localparam int unsigned MSH_ROW_RD_RSP_DEPTH = 8;

  typedef logic [MSH_ROW_RD_REQ_W-1:0] msh_row_rd_req_t;
  typedef logic [MSH_ROW_RD_RSP_W-1:0] msh_row_rd_rsp_t;
  typedef logic [MSH_DBUS_W-1:0]       msh_dbus_t;
  typedef logic [MSH_CRDT_W-1:0]       msh_crdt_cnt_t;

  typedef enum logic [1:0] {
    INIT     = 2'd0,
    RUN      = 2'd1,
    DRAIN    = 2'd2,
    QUIESCED = 2'd3
  } msh_rrc_state_t;

endpackage

// File: rtl/mby_msh_row_rd_req_ctrl_if.sv
// Client/mesh-facing signal bundle of the row read-request controller.
// slave = controller side, master = client/mesh/test side.
interface mby_msh_row_rd_req_ctrl_if;
  import mby_msh_pkg::*;

  logic             i_req_vld;
  msh_row_rd_req_t  i_req;
  logic             o_req_rdy;
  logic             o_rd_req_vld;
  msh_row_rd_req_t  o_rd_req;
  msh_crdt_cnt_t    i_crdt_rtn_cnt;
  logic             i_rd_rsp_vld;
  msh_row_rd_rsp_t  i_rd_rsp;
  msh_dbus_t        i_rd_dbus;
  logic             o_rsp_vld;
  msh_row_rd_rsp_t  o_rsp;
  msh_dbus_t        o_dbus;
  logic             i_rsp_rdy;
  logic             o_crdt_rtn_for_rd_rsp;
  logic             i_flush;
  logic             o_idle;
  logic [4:0]       o_crdt_cnt;
  logic             o_err_crdt_ovfl;
  logic             o_err_rsp_ovfl;

  modport slave (
    input  i_req_vld, i_req, i_crdt_rtn_cnt, i_rd_rsp_vld, i_rd_rsp, i_rd_dbus,
           i_rsp_rdy, i_flush,
    output o_req_rdy, o_rd_req_vld, o_rd_req, o_rsp_vld, o_rsp, o_dbus,
           o_crdt_rtn_for_rd_rsp, o_idle, o_crdt_cnt, o_err_crdt_ovfl, o_err_rsp_ovfl
  );

  modport master (
    output i_req_vld, i_req, i_crdt_rtn_cnt, i_rd_rsp_vld, i_rd_rsp, i_rd_dbus,
           i_rsp_rdy, i_flush,
    input  o_req_rdy, o_rd_req_vld, o_rd_req, o_rsp_vld, o_rsp, o_dbus,
           o_crdt_rtn_for_rd_rsp, o_idle, o_crdt_cnt, o_err_crdt_ovfl, o_err_rsp_ovfl
  );

endinterface

// File: rtl/mby_msh_rd_rsp_fifo.sv
// Synchronous response FIFO; a push into a full FIFO succeeds only when a pop
// frees the head in the same cycle, otherwise it is dropped and flagged.
module mby_msh_rd_rsp_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       ovfl
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  always_comb begin
    full    = (count == (AW+1)'(DEPTH));
    empty   = (count == '0);
    pop_ok  = pop && !empty;
    push_ok = push && (!full || pop_ok);
    ovfl    = push && full && !pop_ok;
    rdata   = mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mby_msh_row_rd_req_ctrl.sv
// Requestor-side mesh row read controller: credit-gated request issue,
// buffered response return with per-entry rsp credits, and a quiesce FSM.
module mby_msh_row_rd_req_ctrl
  import mby_msh_pkg::*;
#(
  parameter int unsigned REQ_CRDTS = MSH_ROW_RD_REQ_CRDTS,
  parameter int unsigned RSP_DEPTH = MSH_ROW_RD_RSP_DEPTH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  mby_msh_row_rd_req_ctrl_if.slave    bus
);
  localparam int unsigned FW = MSH_ROW_RD_RSP_W + MSH_DBUS_W;
  localparam logic [5:0]  CRDT_MAX = 6'(REQ_CRDTS);

  msh_rrc_state_t            state;
  logic [4:0]                crdt_cnt;
  logic [5:0]                crdt_base;
  logic [5:0]                crdt_sum;
  logic                      req_rdy;
  logic                      fire;
  logic                      push;
  logic                      pop;
  logic                      quiet;
  logic                      rd_req_vld;
  msh_row_rd_req_t           rd_req;
  logic                      rsp_crdt;
  logic                      idle;
  logic                      err_crdt;
  logic                      err_rsp;
  logic [FW-1:0]             fifo_head;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      fifo_ovfl;
  logic [$clog2(RSP_DEPTH):0] fifo_count;

  mby_msh_rd_rsp_fifo #(
    .WIDTH (FW),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata ({bus.i_rd_rsp, bus.i_rd_dbus}),
    .pop   (pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count),
    .ovfl  (fifo_ovfl)
  );

  // In INIT the full credit grant is loaded and any same-cycle return is added on top.
  always_comb begin
    req_rdy   = (state == RUN) && (crdt_cnt != '0);
    fire      = bus.i_req_vld && req_rdy;
    pop       = !fifo_empty && bus.i_rsp_rdy;
    push      = bus.i_rd_rsp_vld && (state != INIT);
    crdt_base = (state == INIT) ? CRDT_MAX : {1'b0, crdt_cnt};
    crdt_sum  = crdt_base - 6'(fire) + 6'(bus.i_crdt_rtn_cnt);
    quiet     = (crdt_cnt == CRDT_MAX[4:0]) && (fifo_count == '0) && !rd_req_vld;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= INIT;
      idle  <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          state <= RUN;
          idle  <= 1'b0;
        end
        RUN: begin
          state <= bus.i_flush ? DRAIN : RUN;
          idle  <= 1'b0;
        end
        DRAIN: begin
          if (!bus.i_flush) begin
            state <= RUN;
            idle  <= 1'b0;
          end else if (quiet) begin
            state <= QUIESCED;
            idle  <= 1'b1;
          end
        end
        QUIESCED: begin
          if (!bus.i_flush) begin
            state <= RUN;
            idle  <= 1'b0;
          end
        end
        default: begin
          state <= INIT;
          idle  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crdt_cnt   <= '0;
      rd_req_vld <= 1'b0;
      rd_req     <= '0;
      rsp_crdt   <= 1'b0;
      err_crdt   <= 1'b0;
      err_rsp    <= 1'b0;
    end else begin
      crdt_cnt   <= (crdt_sum > CRDT_MAX) ? CRDT_MAX[4:0] : crdt_sum[4:0];
      err_crdt   <= err_crdt || (crdt_sum > CRDT_MAX);
      err_rsp    <= err_rsp || fifo_ovfl;
      rd_req_vld <= fire;
      if (fire) rd_req <= bus.i_req;
      rsp_crdt   <= pop;
    end
  end

  assign bus.o_req_rdy             = req_rdy;
  assign bus.o_rd_req_vld          = rd_req_vld;
  assign bus.o_rd_req              = rd_req;
  assign bus.o_rsp_vld             = !fifo_empty;
  assign bus.o_rsp                 = fifo_empty ? '0 : fifo_head[FW-1 -: MSH_ROW_RD_RSP_W];
  assign bus.o_dbus                = fifo_empty ? '0 : fifo_head[MSH_DBUS_W-1:0];
  assign bus.o_crdt_rtn_for_rd_rsp = rsp_crdt;
  assign bus.o_idle                = idle;
  assign bus.o_crdt_cnt            = crdt_cnt;
  assign bus.o_err_crdt_ovfl       = err_crdt;
  assign bus.o_err_rsp_ovfl        = err_rsp;

endmodule
